ps2_rx_frame: RTL and testbench
===============================

# ps2_rx_frame

Upstream receive stage of the keyboard path: synchronizes and de-glitches the raw PS/2 clock/data pins, deserializes 11-bit device-to-host frames, and checks parity and stop bits. It folds the E0 (extended) and F0 (break) prefixes into flags on the following code. It delivers one decoded scan code per key event, with a single-cycle valid strobe, to the key-decode stage that drives the per-player direction lines.

## Interface
- FILTER_LEN, 8: consecutive identical ps2c samples needed to change the filtered clock level (range 2..16).
- TIMEOUT, 200000: idle clk cycles allowed between falling edges inside a frame before abort (2 ms at 100 MHz).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- ps2c  in  1  raw PS/2 clock pin, asynchronous.
- ps2d  in  1  raw PS/2 data pin, asynchronous.
- scan_code  out  8  last completed non-prefix scan code.
- is_break  out  1  scan_code was preceded by F0 (key release).
- is_extended  out  1  scan_code was preceded by E0.
- code_valid  out  1  one-cycle strobe: scan_code/flags updated this cycle.
- frame_err  out  1  one-cycle strobe: frame discarded (parity, stop or timeout).

## Operation
- Reset (reset=0 at a clk edge): all outputs 0, FSM to IDLE, prefix flags cleared, bit counter 0, timeout counter 0, filtered clock = 1, sync flops = 1.
- ps2c and ps2d each pass through a 2-flop synchronizer. ps2c then passes through the filter: shift register of FILTER_LEN samples. Filtered level goes 0 when all samples are 0 and goes 1 when all samples are 1; otherwise it holds. fall = filtered level 1 -> 0.
- Data is sampled from the synchronized ps2d on each fall.
- FSM states and transitions:
  - IDLE: on fall with data=0 (start bit), go to DATA, bit_cnt=0. On fall with data=1, stay in IDLE; this is not an error.
  - DATA: on each fall, shift the bit in LSB-first. After the 8th bit go to PARITY.
  - PARITY: on fall, latch the bit and go to STOP.
  - STOP: on fall, the frame is good if data=1 and the parity is odd (popcount of data bits + parity bit is odd). Otherwise it is bad. Either way go to IDLE.
- Good frame with byte E0: set ext_pend; no strobe.
- Good frame with byte F0: set brk_pend; no strobe.
- Any other good byte: scan_code <= byte, is_extended <= ext_pend, is_break <= brk_pend, code_valid=1 for one cycle; then clear both pending flags.
- Bad frame: frame_err=1 for one cycle, both pending flags cleared, scan_code/flags unchanged.
- Timeout: outside IDLE, the counter increments every cycle and resets on each fall. On reaching TIMEOUT: frame_err=1 for one cycle, return to IDLE, discard the partial byte, clear the pending flags.
- Sequences E0 F0 xx and F0 E0 xx are equivalent. A repeated E0 or F0 simply keeps its flag set.
- scan_code, is_break and is_extended hold their values between strobes.
- code_valid and frame_err are never high in the same cycle.

## Timing
- Fall detection: FILTER_LEN+2 cycles after ps2c goes low and stays stable (2 sync + FILTER_LEN filter fill), registered.
- code_valid / frame_err rise on the clk edge following the stop-bit fall detection, i.e. FILTER_LEN+3 cycles after the raw stop-bit ps2c falling edge.
- Glitches on ps2c shorter than FILTER_LEN cycles produce no fall.
- Assertion of reset mid-frame aborts silently: no frame_err.
- No backpressure: the consumer must take code_valid in its cycle. Minimum strobe spacing is one PS/2 frame (~0.6 ms).

## Structure
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_DATA_BITS=8.
  - Timeout counter width as clog2(TIMEOUT+1).
- Sub-module ps2_clk_filter: synchronizer + FILTER_LEN debounce + registered fall output, parameterized by FILTER_LEN. Instantiate it once for ps2c. ps2d uses only the 2-flop synchronizer.

## Test plan
- Plain key: frame for 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1), PS/2 period 80 us -> code_valid pulse, scan_code=0x1C, is_break=0, is_extended=0, FILTER_LEN+3 cycles after the stop-bit fall.
- Release: frames F0 then 1C -> exactly one code_valid, scan_code=0x1C, is_break=1, is_extended=0.
- Extended release: E0, F0, 6B -> one code_valid, scan_code=0x6B, is_break=1, is_extended=1. A following plain 0x1D arrives with both flags 0.
- Errors:
  - 0x1C sent with parity 1 -> frame_err pulse, no code_valid, scan_code unchanged.
  - Next good 0x23 decodes normally.
  - F0 then a bad-stop frame -> frame_err; next 0x1C has is_break=0.
- Stall and glitch:
  - Stop ps2c after 4 data bits for TIMEOUT+10 cycles -> one frame_err, FSM in IDLE, next full frame 0x1C decodes.
  - A ps2c low pulse of FILTER_LEN-1 cycles in IDLE -> no state change.
- Reset mid-frame: assert reset low for 1 cycle after 5 bits -> outputs 0, no strobe. Next complete frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receive path
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam int         PS2_DATA_BITS = 8;

    // Width of a counter that must be able to hold the value TIMEOUT itself
    function automatic int ps2_tmo_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - ps2c synchronizer, debounce filter and fall detector
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2c,
    output logic o_fall
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-2:0] r_hist;
    logic                  r_level;
    logic                  r_fall;
    logic [FILTER_LEN-1:0] w_window;
    logic                  w_all_low;
    logic                  w_all_high;

    // The newest synchronized sample is part of the window so that a stable
    // low is recognised exactly FILTER_LEN+2 cycles after the pin drops.
    assign w_window   = {r_hist, r_sync[1]};
    assign w_all_low  = (w_window == '0);
    assign w_all_high = &w_window;
    assign o_fall     = r_fall;

    // Synchronize the pin, track sample history, update level, register fall
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync  <= 2'b11;
            r_hist  <= '1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_ps2c};
            r_hist <= w_window[FILTER_LEN-2:0];
            if (w_all_low) begin
                r_level <= 1'b0;
            end else if (w_all_high) begin
                r_level <= 1'b1;
            end
            r_fall <= r_level & w_all_low;
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with E0/F0 prefix folding
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] scan_code,
    output logic       is_break,
    output logic       is_extended,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TMO_W     = ps2_tmo_width(TIMEOUT);
    localparam int BIT_CNT_W = $clog2(PS2_DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PS2_DATA_BITS - 1);
    localparam logic [TMO_W-1:0]     TMO_MAX  = TMO_W'(TIMEOUT);

    ps2_state_t             r_state;
    ps2_state_t             w_next_state;
    logic [1:0]             r_d_sync;
    logic [7:0]             r_shift;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   r_par;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_ext_pend;
    logic                   r_brk_pend;
    logic                   w_fall;
    logic                   w_data;
    logic                   w_tmo_hit;
    logic                   w_frame_ok;
    logic                   w_frame_bad;
    logic                   w_timeout;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .i_ps2c (ps2c),
        .o_fall (w_fall)
    );

    assign w_data    = r_d_sync[1];
    assign w_tmo_hit = (r_tmo == TMO_MAX) && !w_fall;

    // Two-flop synchronizer for the data pin
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d_sync <= 2'b11;
        end else begin
            r_d_sync <= {r_d_sync[0], ps2d};
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus frame completion / abort decisions
    always_comb begin
        w_next_state = r_state;
        w_frame_ok   = 1'b0;
        w_frame_bad  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall && !w_data) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_fall) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_next_state = PARITY;
                    end
                end else if (w_tmo_hit) begin
                    w_next_state = IDLE;
                    w_timeout    = 1'b1;
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_next_state = STOP;
                end else if (w_tmo_hit) begin
                    w_next_state = IDLE;
                    w_timeout    = 1'b1;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_next_state = IDLE;
                    // Odd parity over data+parity and a high stop bit
                    if (w_data && (^{r_shift, r_par})) begin
                        w_frame_ok = 1'b1;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_next_state = IDLE;
                    w_timeout    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Deserializer, inter-edge timer, prefix folding and output strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par       <= 1'b0;
            r_tmo       <= '0;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            scan_code   <= '0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            code_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (r_state == IDLE || w_fall) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_fall) begin
                case (r_state)
                    IDLE:    r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    PARITY:  r_par <= w_data;
                    default: ;
                endcase
            end

            if (w_frame_bad || w_timeout) begin
                frame_err  <= 1'b1;
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (w_frame_ok) begin
                if (r_shift == PS2_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    scan_code   <= r_shift;
                    is_extended <= r_ext_pend;
                    is_break    <= r_brk_pend;
                    code_valid  <= 1'b1;
                    r_ext_pend  <= 1'b0;
                    r_brk_pend  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - scoreboard bench for ps2_rx_frame
module tb_ps2_rx_frame;

    localparam int FL   = 8;
    localparam int TMO  = 300;
    localparam int HALF = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] scan_code;
    logic       is_break;
    logic       is_extended;
    logic       code_valid;
    logic       frame_err;

    ps2_rx_frame #(
        .FILTER_LEN(FL),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .scan_code  (scan_code),
        .is_break   (is_break),
        .is_extended(is_extended),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit         m_ext_pend = 0;
    bit         m_brk_pend = 0;
    logic [7:0] m_code     = 8'h00;
    bit         m_brk_out  = 0;
    bit         m_ext_out  = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push_exp(input bit err, input int due);
        exp_t e;
        e.err  = err;
        e.code = m_code;
        e.brk  = m_brk_out;
        e.ext  = m_ext_out;
        e.due  = due;
        q.push_back(e);
    endtask

    // Key-event model: a completed 11-bit frame as seen by the consumer
    task automatic model_frame(input logic [10:0] f, input int stop_cyc);
        logic [7:0] b;
        bit good;
        b = f[8:1];
        good = (f[0] == 1'b0) && (f[10] == 1'b1) && ($countones(f[9:1]) % 2 == 1);
        if (!good) begin
            m_ext_pend = 0;
            m_brk_pend = 0;
            push_exp(1'b1, stop_cyc + FL + 3);
        end else if (b == 8'hE0) begin
            m_ext_pend = 1;
        end else if (b == 8'hF0) begin
            m_brk_pend = 1;
        end else begin
            m_code     = b;
            m_brk_out  = m_brk_pend;
            m_ext_out  = m_ext_pend;
            m_ext_pend = 0;
            m_brk_pend = 0;
            push_exp(1'b0, stop_cyc + FL + 3);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit v);
        ps2d = v;
        wait_cyc(HALF / 2);
        ps2c = 1'b0;
    endtask

    task automatic finish_bit();
        wait_cyc(HALF);
        ps2c = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            send_bit(f[i]);
            if (i == 10) model_frame(f, cyc);
            finish_bit();
        end
        ps2d = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        send_bit(1'b0);
        finish_bit();
        for (int i = 0; i < nbits; i++) begin
            send_bit(b[i]);
            finish_bit();
        end
        ps2d = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest expected event
    always @(negedge clk) begin
        if (reset) begin
            if (code_valid && frame_err) check("both_strobes", 1, 0);
            if (code_valid || frame_err) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: code_valid=%0b frame_err=%0b scan_code=%0h required no strobe (cycle %0d)",
                             code_valid, frame_err, scan_code, cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("strobe_kind_err", frame_err, mon_e.err);
                    check("scan_code", scan_code, mon_e.code);
                    check("is_break", is_break, mon_e.brk);
                    check("is_extended", is_extended, mon_e.ext);
                    if (mon_e.due >= 0) check("strobe_latency", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_scan_code"}, scan_code, 0);
        check({tag, "_is_break"}, is_break, 0);
        check({tag, "_is_extended"}, is_extended, 0);
        check({tag, "_code_valid"}, code_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        reset = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        wait_cyc(5);
        check_outputs_zero("reset");
        reset = 1'b1;
        wait_cyc(20);

        // plain key, release, extended release, plain after extended
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h6B, 0, 0);
        send_frame(8'h1D, 0, 0);

        // bad parity, recovery, bad stop clears pending break
        send_frame(8'h1C, 1, 0);
        send_frame(8'h23, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h55, 0, 1);
        send_frame(8'h1C, 0, 0);

        // F0 E0 order and repeated prefix
        send_frame(8'hF0, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h74, 0, 0);

        // stall mid-frame with a pending break
        send_frame(8'hF0, 0, 0);
        send_partial(8'hA5, 4);
        m_ext_pend = 0;
        m_brk_pend = 0;
        push_exp(1'b1, -1);
        wait_cyc(TMO + 60);
        send_frame(8'h1C, 0, 0);

        // short glitch in idle
        ps2c = 1'b0;
        wait_cyc(FL - 1);
        ps2c = 1'b1;
        wait_cyc(40);
        send_frame(8'h1C, 0, 0);

        // reset mid-frame with a pending break
        send_frame(8'hF0, 0, 0);
        send_partial(8'h1C, 5);
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(1);
        check_outputs_zero("midreset");
        reset = 1'b1;
        m_ext_pend = 0;
        m_brk_pend = 0;
        m_code     = 8'h00;
        m_brk_out  = 0;
        m_ext_out  = 0;
        wait_cyc(40);
        send_frame(8'h1C, 0, 0);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) send_frame(b, 1, 0);
                else                           send_frame(b, 0, 1);
            end else begin
                send_frame(b, 0, 0);
            end
        end

        wait_cyc(50);
        check("pending_expected_events", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
